multi_cycle_proc_controller: RTL and testbench

- Multi-cycle successor to the single-cycle processor controller, with the same 4-bit opcode classes: ALU-R/I, LOAD/STORE, CMP-R/I, BRANCH and JAL.
- A registered FSM sequences FETCH/DECODE/EXEC/MEM/WB against handshaked instruction and data memories.
- Adds parametrised field widths, a bus-timeout trap, an illegal-opcode trap and a retired-instruction counter.
- Sits between the memory interfaces and the datapath (regfile, ALU, PC muxes).

---
 rtl/multi_cycle_proc_controller.sv | 183 ++++++++++++++++++
 tb/tb_multi_cycle_proc_controller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_proc_controller.sv
// Multi-cycle processor controller: FETCH/DECODE/EXEC/MEM/WB sequencing against
// handshaked memories, with illegal-opcode and bus-timeout traps and a retire counter.
module multi_cycle_proc_controller #(
  parameter int unsigned REG_IDX_W = 4,
  parameter int unsigned IMM_W     = 16,
  parameter int unsigned INSTR_W   = 32,
  parameter int unsigned WAIT_MAX  = 15,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INSTR_W-1:0]   instr,
  output logic                 imem_req,
  input  logic                 imem_ready,
  output logic                 dmem_req,
  output logic                 dmem_we,
  input  logic                 dmem_ready,
  input  logic                 alu_cond,
  output logic [3:0]           alu_func,
  output logic                 alu_alt_op,
  output logic                 alu_src2_sel,
  output logic [IMM_W-1:0]     imm,
  output logic [REG_IDX_W-1:0] rd0_idx,
  output logic [REG_IDX_W-1:0] rd1_idx,
  output logic [REG_IDX_W-1:0] wr_idx,
  output logic                 reg_wr_en,
  output logic [1:0]           reg_wr_sel,
  output logic                 pc_load,
  output logic [1:0]           pc_sel,
  output logic                 illegal,
  output logic                 bus_err,
  output logic                 halted,
  output logic [CNT_W-1:0]     retired
);

  localparam int unsigned WCNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WCNT_W-1:0] WAIT_LIM = WCNT_W'(WAIT_MAX);

  localparam logic [3:0] OP_ALU_R  = 4'b0000;
  localparam logic [3:0] OP_ALU_I  = 4'b1000;
  localparam logic [3:0] OP_STORE  = 4'b0101;
  localparam logic [3:0] OP_LOAD   = 4'b1001;
  localparam logic [3:0] OP_CMP_R  = 4'b0010;
  localparam logic [3:0] OP_CMP_I  = 4'b1010;
  localparam logic [3:0] OP_BRANCH = 4'b0110;
  localparam logic [3:0] OP_JAL    = 4'b1011;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t              state, state_d;
  logic [INSTR_W-1:0]  ir, ir_d;
  logic [WCNT_W-1:0]   cnt, cnt_d;
  logic                illegal_d, bus_err_d, retire;
  logic [3:0]          opcode;
  logic                is_store, is_load, is_branch, is_jal, is_rform, legal;
  logic [REG_IDX_W-1:0] f0, f1, f2;

  assign opcode    = ir[3:0];
  assign is_store  = (opcode == OP_STORE);
  assign is_load   = (opcode == OP_LOAD);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_rform  = (opcode == OP_ALU_R) || (opcode == OP_CMP_R);
  assign legal     = is_rform || is_store || is_load || is_branch || is_jal ||
                     (opcode == OP_ALU_I) || (opcode == OP_CMP_I);

  assign f0 = ir[INSTR_W-1 -: REG_IDX_W];
  assign f1 = ir[INSTR_W-1-REG_IDX_W -: REG_IDX_W];
  assign f2 = ir[INSTR_W-1-2*REG_IDX_W -: REG_IDX_W];

  // Index/select/control outputs are pure IR decodes; only strobes depend on state.
  assign wr_idx       = f0;
  assign rd0_idx      = (is_store || is_branch) ? f0 : f1;
  assign rd1_idx      = (is_store || is_branch) ? f1 : (is_rform ? f2 : '0);
  assign alu_func     = ir[7:4];
  assign imm          = ir[8 +: IMM_W];
  assign alu_src2_sel = (opcode == OP_ALU_I) || (opcode == OP_CMP_I) ||
                        is_load || is_store || is_jal;
  assign alu_alt_op   = (opcode == OP_CMP_R) || (opcode == OP_CMP_I) || is_branch;
  assign reg_wr_sel   = is_load ? 2'b01 : (is_jal ? 2'b10 : 2'b00);
  assign pc_sel       = is_branch ? {1'b0, alu_cond} : (is_jal ? 2'b10 : 2'b00);
  assign dmem_we      = (state == S_MEM) && is_store;
  assign halted       = (state == S_TRAP);

  always_comb begin
    state_d   = state;
    ir_d      = ir;
    cnt_d     = '0;
    illegal_d = illegal;
    bus_err_d = bus_err;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    reg_wr_en = 1'b0;
    pc_load   = 1'b0;
    retire    = 1'b0;
    unique case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end else if (cnt == WAIT_LIM) begin
          bus_err_d = 1'b1;
          state_d   = S_TRAP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end
      end
      S_EXEC: begin
        if (is_branch) begin
          pc_load = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          if (is_store) begin
            pc_load = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (cnt == WAIT_LIM) begin
          bus_err_d = 1'b1;
          state_d   = S_TRAP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_WB: begin
        reg_wr_en = 1'b1;
        pc_load   = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP: ;
      default: state_d = S_FETCH;
    endcase
    // Strobes are forced low in the reset cycle regardless of the current state.
    if (!rst_n) begin
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      reg_wr_en = 1'b0;
      pc_load   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      ir      <= '0;
      cnt     <= '0;
      retired <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state   <= state_d;
      ir      <= ir_d;
      cnt     <= cnt_d;
      illegal <= illegal_d;
      bus_err <= bus_err_d;
      if (retire) retired <= retired + 1'b1;
    end
  end

endmodule

// File: tb/tb_multi_cycle_proc_controller.sv
// Directed bench for multi_cycle_proc_controller: instruction classes, memory waits,
// reset mid-wait, timeout boundary and both traps.
module tb_multi_cycle_proc_controller;

  logic        clk = 1'b0;
  logic        rst_n, imem_ready, dmem_ready, alu_cond;
  logic [31:0] instr;
  logic        imem_req, dmem_req, dmem_we, alu_alt_op, alu_src2_sel;
  logic [3:0]  alu_func;
  logic [15:0] imm;
  logic [3:0]  rd0_idx, rd1_idx, wr_idx;
  logic        reg_wr_en, pc_load, illegal, bus_err, halted;
  logic [1:0]  reg_wr_sel, pc_sel;
  logic [31:0] retired;

  int checks = 0;
  int failures = 0;

  multi_cycle_proc_controller #(
    .REG_IDX_W(4), .IMM_W(16), .INSTR_W(32), .WAIT_MAX(15), .CNT_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .alu_cond(alu_cond), .alu_func(alu_func), .alu_alt_op(alu_alt_op),
    .alu_src2_sel(alu_src2_sel), .imm(imm),
    .rd0_idx(rd0_idx), .rd1_idx(rd1_idx), .wr_idx(wr_idx),
    .reg_wr_en(reg_wr_en), .reg_wr_sel(reg_wr_sel),
    .pc_load(pc_load), .pc_sel(pc_sel),
    .illegal(illegal), .bus_err(bus_err), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe vector order: {imem_req, dmem_req, reg_wr_en, pc_load}
  task automatic chk_st(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, imem_req, dmem_req, reg_wr_en, pc_load}, {28'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0; instr = '0; imem_ready = 1'b0; dmem_ready = 1'b0; alu_cond = 1'b0;
    step();
    chk_st("rst_strobes", 4'b0000);
    chk("rst_retired", retired, 0);
    chk("rst_flags", {29'd0, illegal, bus_err, halted}, 0);
    rst_n = 1'b1; #1;
    chk_st("post_rst_fetch", 4'b1000);

    // ALU-R
    instr = 32'h3210_0010; imem_ready = 1'b1;
    step(); imem_ready = 1'b0; instr = '0; #1;
    chk_st("alur_dec", 4'b0000);
    chk("alur_rd", {24'd0, rd0_idx, rd1_idx}, 32'h21);
    step();
    chk_st("alur_exec", 4'b0000);
    chk("alur_func", {28'd0, alu_func}, 1);
    chk("alur_ctl", {30'd0, alu_alt_op, alu_src2_sel}, 0);
    step();
    chk_st("alur_wb", 4'b0011);
    chk("alur_wr", {28'd0, wr_idx}, 3);
    chk("alur_sel", {28'd0, reg_wr_sel, pc_sel}, 0);
    step();
    chk_st("alur_next", 4'b1000);
    chk("alur_retired", retired, 1);

    // BRANCH taken then not taken
    for (int k = 0; k < 2; k++) begin
      instr = 32'h1200_0406; imem_ready = 1'b1; alu_cond = (k == 0);
      step(); imem_ready = 1'b0; #1;
      chk_st("br_dec", 4'b0000);
      chk("br_rd", {24'd0, rd0_idx, rd1_idx}, 32'h12);
      step();
      chk_st("br_exec", 4'b0001);
      chk("br_pcsel", {30'd0, pc_sel}, (k == 0) ? 32'd1 : 32'd0);
      chk("br_alt", {31'd0, alu_alt_op}, 1);
      chk("br_imm", {16'd0, imm}, 4);
      step();
      chk_st("br_next", 4'b1000);
      chk("br_retired", retired, 2 + k);
    end
    alu_cond = 1'b0;

    // LOAD with 3 data wait cycles
    instr = 32'h7600_0209; imem_ready = 1'b1;
    step(); imem_ready = 1'b0; #1;
    step();
    chk_st("ld_exec", 4'b0000);
    chk("ld_src2", {31'd0, alu_src2_sel}, 1);
    for (int i = 0; i < 4; i++) begin
      step(); dmem_ready = (i == 3); #1;
      chk_st("ld_mem", 4'b0100);
      chk("ld_we", {31'd0, dmem_we}, 0);
    end
    step(); dmem_ready = 1'b0; #1;
    chk_st("ld_wb", 4'b0011);
    chk("ld_sel", {30'd0, reg_wr_sel}, 1);
    chk("ld_idx", {24'd0, wr_idx, rd0_idx}, 32'h76);
    step();
    chk_st("ld_next", 4'b1000);
    chk("ld_retired", retired, 4);

    // STORE, zero wait
    instr = 32'h8900_0305; imem_ready = 1'b1;
    step(); imem_ready = 1'b0; #1;
    chk("st_rd", {24'd0, rd0_idx, rd1_idx}, 32'h89);
    step();
    chk("st_src2", {31'd0, alu_src2_sel}, 1);
    step(); dmem_ready = 1'b1; #1;
    chk_st("st_mem", 4'b0101);
    chk("st_we", {31'd0, dmem_we}, 1);
    chk("st_pcsel", {30'd0, pc_sel}, 0);
    step(); dmem_ready = 1'b0; #1;
    chk_st("st_next", 4'b1000);
    chk("st_retired", retired, 5);

    // JAL
    instr = 32'h5400_010B; imem_ready = 1'b1;
    step(); imem_ready = 1'b0; #1;
    step();
    chk_st("jal_exec", 4'b0000);
    step();
    chk_st("jal_wb", 4'b0011);
    chk("jal_sel", {28'd0, reg_wr_sel, pc_sel}, 32'hA);
    chk("jal_idx", {24'd0, wr_idx, rd0_idx}, 32'h54);
    chk("jal_imm", {16'd0, imm}, 1);
    chk("jal_src2", {31'd0, alu_src2_sel}, 1);
    step();
    chk("jal_retired", retired, 6);

    // Reset during a LOAD's data wait
    instr = 32'h7600_0209; imem_ready = 1'b1;
    step(); imem_ready = 1'b0; #1;
    step(); step();
    chk_st("mw_mem", 4'b0100);
    step(); rst_n = 1'b0; #1;
    chk_st("mw_rst_cycle", 4'b0000);
    step(); rst_n = 1'b1; #1;
    chk_st("mw_fetch", 4'b1000);
    chk("mw_retired", retired, 0);

    // Fetch ready arriving exactly at the wait limit is a success (ALU-I)
    for (int i = 0; i < 15; i++) begin
      chk_st("edge_wait", 4'b1000);
      step();
    end
    instr = 32'hAB00_1238; imem_ready = 1'b1; #1;
    chk_st("edge_req", 4'b1000);
    step(); imem_ready = 1'b0; #1;
    chk("edge_flags", {30'd0, bus_err, halted}, 0);
    chk("alui_rd", {24'd0, rd0_idx, rd1_idx}, 32'hB0);
    step();
    chk("alui_src2", {31'd0, alu_src2_sel}, 1);
    step();
    chk_st("alui_wb", 4'b0011);
    chk("alui_wr", {28'd0, wr_idx}, 32'hA);
    step();
    chk("alui_retired", retired, 1);

    // Fetch timeout trap
    for (int i = 0; i < 16; i++) begin
      chk_st("to_req", 4'b1000);
      chk("to_noerr", {31'd0, bus_err}, 0);
      step();
    end
    chk("to_flags", {30'd0, bus_err, halted}, 32'h3);
    chk_st("to_trap", 4'b0000);
    imem_ready = 1'b1;
    step(); step();
    chk("to_absorb", {30'd0, bus_err, halted}, 32'h3);
    chk_st("to_absorb_st", 4'b0000);
    imem_ready = 1'b0;

    // Illegal opcode trap
    rst_n = 1'b0;
    step(); rst_n = 1'b1; #1;
    chk("rst2_flags", {29'd0, illegal, bus_err, halted}, 0);
    instr = 32'h0000_000F; imem_ready = 1'b1;
    step(); imem_ready = 1'b0; #1;
    chk("ill_dec", {30'd0, illegal, halted}, 0);
    step();
    chk("ill_flags", {29'd0, illegal, halted, bus_err}, 32'h6);
    chk_st("ill_trap", 4'b0000);
    imem_ready = 1'b1;
    step(); step();
    chk("ill_absorb", {30'd0, illegal, halted}, 32'h3);
    chk_st("ill_absorb_st", 4'b0000);
    chk("ill_retired", retired, 0);
    imem_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
